// File: rtl/lc3b_mem_sequencer_pkg.sv
// rtl/lc3b_mem_sequencer_pkg.sv - shared state type for the LC-3b memory-access sequencer
package lc3b_mem_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_PTR,
        SEQ_PTR_GAP,
        SEQ_ACCESS,
        SEQ_GAP_DONE
    } seq_state_e;

    // After a pointer hop (or at accept) the next strobe is another hop while depth remains.
    function automatic seq_state_e next_strobe_state(input logic more_ptr);
        return more_ptr ? SEQ_PTR : SEQ_ACCESS;
    endfunction

endpackage

// File: rtl/lc3b_seq_timer.sv
// rtl/lc3b_seq_timer.sv - saturating wait counter that flags the wait cycle reaching LIMIT
module lc3b_seq_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT_C)) begin
            count <= count + 1'b1;
        end
    end

    // High in the unanswered wait cycle whose edge brings the count to LIMIT.
    assign expired = enable && !clear && (count == LAST_C);

endmodule

// File: rtl/lc3b_mem_sequencer.sv
// rtl/lc3b_mem_sequencer.sv - pointer-chasing load/store engine between control FSM and memory port
module lc3b_mem_sequencer
    import lc3b_mem_sequencer_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int MAX_IND = 2,
    parameter int TIMEOUT = 255,
    localparam int IND_W  = $clog2(MAX_IND + 1),
    localparam int LANE_W = $clog2(DATA_W / 8),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [IND_W-1:0]  req_ind,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_byte_enable,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef struct packed {
        logic              write;
        logic              is_byte;
        logic [IND_W-1:0]  ind;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    localparam logic [IND_W-1:0] MAX_IND_C = IND_W'(MAX_IND);

    function automatic logic [DATA_W-1:0] lane_zext(input logic [DATA_W-1:0] word,
                                                    input logic [LANE_W-1:0] lane);
        logic [DATA_W-1:0] shifted;
        shifted = word >> (8 * lane);
        return DATA_W'(shifted[7:0]);
    endfunction

    function automatic logic [BE_W-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
        return BE_W'(1) << lane;
    endfunction

    seq_state_e        state, state_d;
    req_t              req_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              strobing;
    logic              timeout_hit;
    logic [ADDR_W-1:0] aligned_addr;

    assign strobing     = (state == SEQ_PTR) || (state == SEQ_ACCESS);
    assign aligned_addr = {req_q.addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

    generate
        if (TIMEOUT > 0) begin : g_timer
            lc3b_seq_timer #(.LIMIT(TIMEOUT)) u_timer (
                .clk     (clk),
                .rst_n   (rst_n),
                .clear   (!strobing),
                .enable  (strobing && !mem_resp),
                .expired (timeout_hit)
            );
        end else begin : g_no_timer
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // mem_resp wins over a simultaneous timeout, so it is tested first.
    always_comb begin
        state_d = state;
        unique case (state)
            SEQ_IDLE: begin
                if (req_valid) begin
                    state_d = (req_ind > MAX_IND_C) ? SEQ_GAP_DONE
                                                    : next_strobe_state(req_ind != '0);
                end
            end
            SEQ_PTR: begin
                if (mem_resp)         state_d = SEQ_PTR_GAP;
                else if (timeout_hit) state_d = SEQ_GAP_DONE;
            end
            SEQ_PTR_GAP:  state_d = next_strobe_state(req_q.ind != '0);
            SEQ_ACCESS: begin
                if (mem_resp || timeout_hit) state_d = SEQ_GAP_DONE;
            end
            SEQ_GAP_DONE: state_d = SEQ_IDLE;
            default:      state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                SEQ_IDLE: begin
                    if (req_valid) begin
                        req_q <= '{write: req_write, is_byte: req_byte, ind: req_ind,
                                   addr: req_addr, wdata: req_wdata};
                        err_q <= (req_ind > MAX_IND_C);
                    end
                end
                SEQ_PTR: begin
                    if (mem_resp) begin
                        req_q.addr <= mem_rdata[ADDR_W-1:0];
                        req_q.ind  <= req_q.ind - 1'b1;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                SEQ_ACCESS: begin
                    if (mem_resp) begin
                        if (!req_q.write) begin
                            rdata_q <= req_q.is_byte ? lane_zext(mem_rdata, req_q.addr[LANE_W-1:0])
                                                     : mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == SEQ_IDLE);
    assign busy      = (state != SEQ_IDLE);
    assign done      = (state == SEQ_GAP_DONE);
    assign err       = done && err_q;
    assign rdata     = rdata_q;
    assign mem_read  = (state == SEQ_PTR) || ((state == SEQ_ACCESS) && !req_q.write);
    assign mem_write = (state == SEQ_ACCESS) && req_q.write;

    // Address, lanes and data are driven only while strobing so idle cycles present zeros.
    always_comb begin
        mem_address     = '0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        if (state == SEQ_PTR) begin
            mem_address     = aligned_addr;
            mem_byte_enable = '1;
        end else if (state == SEQ_ACCESS) begin
            mem_address     = req_q.is_byte ? req_q.addr : aligned_addr;
            mem_byte_enable = req_q.is_byte ? lane_onehot(req_q.addr[LANE_W-1:0]) : '1;
            if (req_q.write) begin
                mem_wdata = req_q.is_byte ? {BE_W{req_q.wdata[7:0]}} : req_q.wdata;
            end
        end
    end

endmodule

// File: tb/tb_lc3b_mem_sequencer.sv
// tb/tb_lc3b_mem_sequencer.sv - scoreboard bench for lc3b_mem_sequencer with a memory responder
module tb_lc3b_mem_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic        req_write = 1'b0, req_byte = 1'b0;
    logic [1:0]  req_ind = '0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        busy, done, err;
    logic [15:0] rdata;
    logic        mem_read, mem_write;
    logic [15:0] mem_address, mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;

    lc3b_mem_sequencer #(.DATA_W(16), .ADDR_W(16), .MAX_IND(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_ind(req_ind), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int err; logic [15:0] rdata; int lat; int acc; } exp_t;
    typedef struct { logic wr; logic [15:0] addr; logic [1:0] be; logic [15:0] wdata; } acc_t;

    exp_t sb_q[$];
    acc_t acc_q[$];
    int   wait_q[$];
    int   force_w[$];
    logic [15:0] model_mem [0:32767];
    logic [15:0] dev_mem   [0:32767];
    logic [15:0] last_rdata = '0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int next_wait();
        int r;
        if (force_w.size() > 0) return force_w.pop_front();
        r = $urandom_range(0, 19);
        if (r < 10) return 0;
        if (r < 17) return $urandom_range(1, 3);
        return $urandom_range(4, 5);
    endfunction

    function automatic acc_t mk_acc(logic wr, logic [15:0] a, logic [1:0] be, logic [15:0] wd);
        acc_t x;
        x.wr = wr; x.addr = a; x.be = be; x.wdata = wd;
        return x;
    endfunction

    // Reference: each access is a strobe of (wait+1) cycles, or TO cycles when wait >= TO;
    // accesses are separated by one idle cycle and done follows the last strobe.
    task automatic plan(input logic wr, input logic bt, input logic [1:0] ind,
                        input logic [15:0] addr, input logic [15:0] wd, output exp_t e);
        int strobe_cyc = 0;
        int n = 0;
        int w;
        logic [15:0] a = addr;
        logic [15:0] word;
        logic [1:0]  be;
        e.err = 0;
        e.acc = 0;
        if (ind > 2) begin
            e.err = 1; e.lat = 1; e.rdata = last_rdata;
            return;
        end
        for (int i = 0; i < int'(ind) && e.err == 0; i++) begin
            w = next_wait();
            wait_q.push_back(w);
            acc_q.push_back(mk_acc(1'b0, {a[15:1], 1'b0}, 2'b11, 16'h0));
            n++;
            if (w >= TO) begin
                e.err = 1; strobe_cyc += TO;
            end else begin
                strobe_cyc += w + 1;
                a = model_mem[a[15:1]];
            end
        end
        if (e.err == 0) begin
            w = next_wait();
            wait_q.push_back(w);
            be = bt ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
            acc_q.push_back(mk_acc(wr, bt ? a : {a[15:1], 1'b0}, be,
                                   bt ? {2{wd[7:0]}} : wd));
            n++;
            if (w >= TO) begin
                e.err = 1; strobe_cyc += TO;
            end else begin
                strobe_cyc += w + 1;
                word = model_mem[a[15:1]];
                if (wr) begin
                    if (!bt)      word = wd;
                    else if (a[0]) word[15:8] = wd[7:0];
                    else          word[7:0] = wd[7:0];
                    model_mem[a[15:1]] = word;
                end else begin
                    last_rdata = bt ? {8'h00, (a[0] ? word[15:8] : word[7:0])} : word;
                end
            end
        end
        e.rdata = last_rdata;
        e.lat = 1 + strobe_cyc + n - 1;
    endtask

    task automatic issue(input logic wr, input logic bt, input logic [1:0] ind,
                         input logic [15:0] addr, input logic [15:0] wd);
        exp_t e;
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout actual=0 required=1");
            return;
        end
        req_valid = 1'b1; req_write = wr; req_byte = bt; req_ind = ind;
        req_addr = addr; req_wdata = wd;
        plan(wr, bt, ind, addr, wd, e);
        e.acc = cyc;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_write = 1'(($urandom)); req_byte = 1'(($urandom)); req_ind = 2'($urandom);
        req_addr = 16'($urandom); req_wdata = 16'($urandom);
        if (ind <= 2 && $urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() > 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_mem_read"}, mem_read, 0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_byte_enable"}, mem_byte_enable, 0);
    endtask

    // Memory responder: answers each strobe after its planned wait and checks the request.
    initial begin
        int cnt = 0;
        int w = 0;
        logic active = 1'b0;
        logic [15:0] a0 = '0;
        logic [15:0] word;
        acc_t x;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0; mem_resp = 1'b0;
            end else if (mem_read || mem_write) begin
                if (!active) begin
                    active = 1'b1; cnt = 0; a0 = mem_address;
                    if (acc_q.size() == 0 || wait_q.size() == 0) begin
                        checks++; errors++; w = 0;
                        $display("FAIL unexpected_strobe actual_addr=%h required=none", mem_address);
                    end else begin
                        x = acc_q.pop_front();
                        w = wait_q.pop_front();
                        chk("strobe_is_write", mem_write, x.wr);
                        chk("mem_address", mem_address, x.addr);
                        chk("mem_byte_enable", mem_byte_enable, x.be);
                        if (x.wr) chk("mem_wdata", mem_wdata, x.wdata);
                    end
                end else begin
                    chk("address_stable", mem_address, a0);
                end
                if (cnt == w) begin
                    mem_resp = 1'b1;
                    word = dev_mem[mem_address[15:1]];
                    if (mem_write) begin
                        if (mem_byte_enable[0]) word[7:0]  = mem_wdata[7:0];
                        if (mem_byte_enable[1]) word[15:8] = mem_wdata[15:8];
                        dev_mem[mem_address[15:1]] = word;
                        mem_rdata = 16'($urandom);
                    end else begin
                        mem_rdata = word;
                    end
                end else begin
                    mem_resp = 1'b0;
                    mem_rdata = 16'($urandom);
                end
                cnt++;
            end else begin
                active = 1'b0;
                mem_resp = ($urandom_range(0, 3) == 0);
                mem_rdata = 16'($urandom);
            end
        end
    end

    // Completion monitor.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    m = sb_q.pop_front();
                    chk("err", err, m.err);
                    chk("rdata", rdata, m.rdata);
                    chk("done_cycle", cyc - m.acc, m.lat);
                    chk("busy_at_done", busy, 1);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        int r;
        for (int i = 0; i < 32768; i++) begin
            v = 16'($urandom);
            model_mem[i] = v;
            dev_mem[i] = v;
        end
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        model_mem[16'h0102 >> 1] = 16'hBEEF; dev_mem[16'h0102 >> 1] = 16'hBEEF;
        force_w = '{0};
        issue(1'b0, 1'b0, 2'd0, 16'h0102, 16'h0);
        force_w = '{3};
        issue(1'b1, 1'b1, 2'd0, 16'h0203, 16'h00A5);
        model_mem[16'h0010 >> 1] = 16'h3000; dev_mem[16'h0010 >> 1] = 16'h3000;
        model_mem[16'h3000 >> 1] = 16'h1234; dev_mem[16'h3000 >> 1] = 16'h1234;
        force_w = '{0, 0};
        issue(1'b0, 1'b0, 2'd1, 16'h0010, 16'h0);
        force_w = '{5};
        issue(1'b0, 1'b0, 2'd0, 16'h0400, 16'h0);
        force_w = '{3};
        issue(1'b0, 1'b0, 2'd0, 16'h0400, 16'h0);
        issue(1'b0, 1'b0, 2'd3, 16'h0500, 16'h0);
        drain();

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            issue(1'($urandom), 1'($urandom), (r == 9) ? 2'd3 : 2'(r % 3),
                  16'($urandom), 16'($urandom));
        end
        drain();

        force_w = '{5};
        issue(1'b0, 1'b0, 2'd1, 16'h0010, 16'h0);
        @(negedge clk);
        chk("ptr_strobe_before_reset", mem_read, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_ptr_reset");
        sb_q.delete(); acc_q.delete(); wait_q.delete(); force_w.delete();
        last_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        force_w = '{0, 1};
        issue(1'b0, 1'b0, 2'd1, 16'h0010, 16'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3b_mem_sequencer.md
# lc3b_mem_sequencer

Parametrised memory-access sequencer for the multicycle LC-3b datapath. It replaces the hand-coded per-opcode memory state chains in the control FSM (LDR/STR, LDB/STB, LDI/STI) with one engine. The control FSM issues a single request: address, read/write, byte/word, and indirection depth. The sequencer performs the pointer dereferences and the final access, handles lane selection and byte enables, and bounds every access with a timeout. It sits between the control FSM/datapath and the memory port.

## Interface
- DATA_W, 16, memory word width in bits; multiple of 8, power of two ≥ 16.
- ADDR_W, 16, address width in bits (byte address).
- MAX_IND, 2, maximum pointer dereferences per request (≥ 1).
- TIMEOUT, 255, cycles a strobe may wait for mem_resp; 0 disables the timeout.
- IND_W, derived, $clog2(MAX_IND+1).
- LANE_W, derived, $clog2(DATA_W/8).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer idle; a request is accepted when req_valid && req_ready.
- req_write  in  1  0 = load, 1 = store (final access only).
- req_byte  in  1  final access is a single byte.
- req_ind  in  IND_W  pointer dereferences before the final access.
- req_addr  in  ADDR_W  initial address.
- req_wdata  in  DATA_W  store data; for byte stores, bits [7:0] are used.
- busy  out  1  request in flight.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; set on timeout or illegal req_ind.
- rdata  out  DATA_W  load result; valid from done, held until the next done.
- mem_read, mem_write  out  1  memory strobes.
- mem_address  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_byte_enable  out  DATA_W/8  lane mask.
- mem_rdata  in  DATA_W  read data, sampled when mem_resp=1.
- mem_resp  in  1  memory completion.

## Operation
- States: IDLE, PTR, PTR_GAP, ACCESS, GAP_DONE (done state). Encode the states as an enum.
- Accept in IDLE:
  - Latch write, byte, wdata and depth.
  - Set cur_addr = req_addr.
  - If req_ind > MAX_IND, go to GAP_DONE with err=1 and perform no memory access.
  - Otherwise go to PTR if depth > 0, else to ACCESS.
- PTR:
  - Full-word read at cur_addr with low LANE_W bits forced to 0 and all byte enables set.
  - On mem_resp: cur_addr ← mem_rdata[ADDR_W-1:0], depth decrements, go to PTR_GAP.
- PTR_GAP: strobes low for one cycle, then go to PTR if depth > 0, else ACCESS.
- ACCESS, word access:
  - Aligned address, byte enables all 1.
  - On a read, rdata ← mem_rdata.
- ACCESS, byte access:
  - Full address; mem_byte_enable is one-hot at lane = cur_addr[LANE_W-1:0].
  - A byte store replicates wdata[7:0] across every lane.
  - A byte load sets rdata ← zero-extended selected lane.
- ACCESS exit: on mem_resp, go to GAP_DONE.
- GAP_DONE: done=1 and strobes low; return to IDLE on the next cycle.
- Timeout:
  - A counter clears on entry to PTR or ACCESS and increments each strobed cycle without mem_resp.
  - When it reaches TIMEOUT (TIMEOUT ≠ 0), drop the strobe, set err=1, leave rdata unchanged, and go to GAP_DONE.
  - A mem_resp arriving in the same cycle the count reaches TIMEOUT wins: normal completion, err=0.
- Ignored inputs:
  - mem_resp outside PTR/ACCESS is ignored.
  - req_valid while busy is ignored, since req_ready=0.

## Timing
- All outputs are registered or state-decoded, with no combinational path from mem_resp to mem_* outputs.
- Reset (asynchronous, any state, mid-access included):
  - Enter IDLE.
  - req_ready=1.
  - busy, done, err, mem_read, mem_write = 0.
  - mem_address, mem_wdata, rdata = 0.
  - mem_byte_enable = 0.
  - Timeout counter = 0.
- Latency, counted from the accept edge = cycle 0 with zero-wait memory:
  - The strobe is high in cycle 1.
  - Each dereference adds 2 cycles.
  - done pulses in cycle 2 + 2·req_ind.
  - Each memory wait cycle adds 1.
- The strobe and address are stable from assertion until the cycle mem_resp is sampled.
- Consecutive accesses are always separated by at least one strobe-low cycle.
- req_ready rises in the cycle after done, so back-to-back requests are spaced 3 + 2·ind cycles apart at minimum.

## Structure
- lc3b_types additions:
  - The sequencer state enum.
  - A req_t packed struct {write, byte, ind, addr, wdata}.
- Sub-module lc3b_seq_timer: a parametrised saturating wait counter with clear/enable/expired outputs.
  - Instantiated once.
  - Excluded when TIMEOUT=0 via a generate block.
- Lane mux and byte-enable decode live in the sequencer as combinational functions.

## Test plan
- Word load, ind=0, addr=0x0102, mem_rdata=0xBEEF with 0 wait → mem_address=0x0102, done in cycle 2, rdata=0xBEEF, err=0.
- Byte store, addr=0x0203, wdata=0x00A5 → mem_byte_enable=2'b10, mem_wdata=0xA5A5, mem_write held for 3 wait cycles until resp, then done.
- LDI-style load, ind=1: M[0x0010]=0x3000, M[0x3000]=0x1234 → two reads separated by a strobe-low cycle, done in cycle 4, rdata=0x1234.
- Timeout with TIMEOUT=4 and mem_resp never asserted → strobe drops after 4 cycles, done=1, err=1, rdata unchanged; then a second simultaneous case with resp arriving on the 4th cycle → err=0.
- Illegal req_ind=3 with MAX_IND=2 → no strobe, done=err=1 in cycle 1.
- rst_n pulled low mid-PTR wait → all outputs 0 immediately, req_ready=1; a new request is then accepted and completes normally.
